usb_packet_buffer_arbiter: RTL and testbench

//  Owns the single-port USB packet buffer RAM and shares it between the core (clk48 domain, via bus bridge) and the USB engine.

---
 rtl/usb_buffer_pkg.sv | 23 ++
 rtl/packet_buffer_ram.sv | 36 +++
 rtl/usb_packet_buffer_arbiter.sv | 155 +++++++++++++++
 tb/tb_usb_packet_buffer_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/usb_buffer_pkg.sv
// Shared types and defaults for the USB packet buffer arbiter and its RAM.
package usb_buffer_pkg;

  localparam int unsigned DEF_DEPTH_WORDS = 256;
  localparam int unsigned DEF_ADDR_W      = 8;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned BE_W            = DATA_W / 8;
  localparam int unsigned WAIT_W          = 4;
  localparam int unsigned CONFLICT_W      = 16;

  typedef enum logic {
    FILL  = 1'b0,
    READY = 1'b1
  } pkt_state_e;

  // Access payload steered to the RAM by the arbiter (address travels separately).
  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } buf_req_t;

endpackage

// File: rtl/packet_buffer_ram.sv
// Single-port packet buffer, byte-enabled write, registered one-cycle read.
module packet_buffer_ram
  import usb_buffer_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int unsigned ADDR_W      = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_q;

  // No reset on storage or read register so the array maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
    if (en_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/usb_packet_buffer_arbiter.sv
// Shares the packet buffer between core and USB engine and tracks packet ownership.
// Optional USB_ARB_CONFLICT_COUNT_EN adds a saturating contention counter output.
module usb_packet_buffer_arbiter
  import usb_buffer_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned MAX_WAIT    = 3
) (
  input  logic              clk48,
  input  logic              rst_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [BE_W-1:0]   core_be,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              usb_req,
  input  logic              usb_we,
  input  logic [ADDR_W-1:0] usb_addr,
  input  logic [BE_W-1:0]   usb_be,
  input  logic [DATA_W-1:0] usb_wdata,
  output logic              usb_gnt,
  output logic              usb_rvalid,
  output logic [DATA_W-1:0] usb_rdata,
  input  logic              usb_packet_done,
  input  logic              core_packet_handled,
  output logic              packet_ready,
  output logic              packet_overrun
`ifdef USB_ARB_CONFLICT_COUNT_EN
  ,
  output logic [CONFLICT_W-1:0] conflict_count
`endif
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  pkt_state_e        state_q, state_d;
  logic              overrun_q, overrun_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              usb_eligible, core_forced;
  logic              core_rvalid_q, usb_rvalid_q;
  logic [DATA_W-1:0] core_hold_q, usb_hold_q;
  logic [DATA_W-1:0] ram_rdata;
  logic [ADDR_W-1:0] ram_addr;
  buf_req_t          core_p, usb_p, ram_p;

  // Arbitration: starvation guard first, then USB, then core.
  always_comb begin
    usb_eligible = usb_req && !((state_q == READY) && usb_we);
    core_forced  = core_req && (wait_q == WAIT_LIMIT);
    core_gnt     = core_forced || (core_req && !usb_eligible);
    usb_gnt      = usb_eligible && !core_forced;
  end

  always_comb begin
    wait_d = wait_q;
    if (!core_req || core_gnt) begin
      wait_d = '0;
    end else if (wait_q != WAIT_LIMIT) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  assign core_p   = '{we: core_we, be: core_be, wdata: core_wdata};
  assign usb_p    = '{we: usb_we, be: usb_be, wdata: usb_wdata};
  assign ram_p    = core_gnt ? core_p : usb_p;
  assign ram_addr = core_gnt ? core_addr : usb_addr;

  packet_buffer_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .clk_i  (clk48),
    .en_i   (core_gnt || usb_gnt),
    .we_i   (ram_p.we),
    .addr_i (ram_addr),
    .be_i   (ram_p.be),
    .wdata_i(ram_p.wdata),
    .rdata_o(ram_rdata)
  );

  // Ownership state register.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:  if (usb_packet_done) state_d = READY;
      READY: if (core_packet_handled) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Handled wins over a simultaneous done: the packet returns to USB and overrun clears.
  always_comb begin
    overrun_d      = overrun_q;
    packet_ready   = (state_q == READY);
    packet_overrun = overrun_q;
    if (state_q == READY) begin
      if (core_packet_handled) begin
        overrun_d = 1'b0;
      end else if (usb_packet_done) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      wait_q        <= '0;
      core_rvalid_q <= 1'b0;
      usb_rvalid_q  <= 1'b0;
      core_hold_q   <= '0;
      usb_hold_q    <= '0;
    end else begin
      wait_q        <= wait_d;
      core_rvalid_q <= core_gnt && !core_we;
      usb_rvalid_q  <= usb_gnt && !usb_we;
      if (core_rvalid_q) core_hold_q <= ram_rdata;
      if (usb_rvalid_q)  usb_hold_q  <= ram_rdata;
    end
  end

  // Each port sees fresh RAM data only on its own rvalid, otherwise its last read.
  assign core_rvalid = core_rvalid_q;
  assign usb_rvalid  = usb_rvalid_q;
  assign core_rdata  = core_rvalid_q ? ram_rdata : core_hold_q;
  assign usb_rdata   = usb_rvalid_q ? ram_rdata : usb_hold_q;

`ifdef USB_ARB_CONFLICT_COUNT_EN
  logic [CONFLICT_W-1:0] conflict_q;

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      conflict_q <= '0;
    end else if (core_req && usb_eligible && (conflict_q != {CONFLICT_W{1'b1}})) begin
      conflict_q <= conflict_q + CONFLICT_W'(1);
    end
  end

  assign conflict_count = conflict_q;
`endif

endmodule

// File: tb/tb_usb_packet_buffer_arbiter.sv
// Directed table-driven bench for usb_packet_buffer_arbiter plus reset corner sequence.
module tb_usb_packet_buffer_arbiter;

  localparam logic [31:0] VD = 32'hDEADBEEF;
  localparam logic [31:0] VX = 32'h11AB3344;
  localparam logic [31:0] VC = 32'hCAFEF00D;
  localparam logic [31:0] VM = 32'h12345678;
  localparam int NV = 37;

  // req: {core_req, core_we, usb_req, usb_we}; ev: {done, handled}
  // eg: {core_gnt, usb_gnt, core_rvalid, usb_rvalid}; est: {packet_ready, packet_overrun}
  typedef struct {
    logic [3:0]  req;
    logic [7:0]  caddr;
    logic [3:0]  cbe;
    logic [31:0] cwd;
    logic [7:0]  uaddr;
    logic [31:0] uwd;
    logic [1:0]  ev;
    logic [3:0]  eg;
    logic [31:0] ecrd;
    logic [31:0] eurd;
    logic [1:0]  est;
  } vec_t;

  logic        clk48 = 1'b0;
  logic        rst_n;
  logic        core_req, core_we, usb_req, usb_we;
  logic [7:0]  core_addr, usb_addr;
  logic [3:0]  core_be, usb_be;
  logic [31:0] core_wdata, usb_wdata;
  logic        core_gnt, core_rvalid, usb_gnt, usb_rvalid;
  logic [31:0] core_rdata, usb_rdata;
  logic        usb_packet_done, core_packet_handled;
  logic        packet_ready, packet_overrun;
`ifdef USB_ARB_CONFLICT_COUNT_EN
  logic [15:0] conflict_count;
`endif

  int   n_pass = 0;
  int   n_total = 0;
  int   cur_step = 0;
  vec_t vecs [NV];

  always #5 clk48 = ~clk48;

  usb_packet_buffer_arbiter dut (
    .clk48              (clk48),
    .rst_n              (rst_n),
    .core_req           (core_req),
    .core_we            (core_we),
    .core_addr          (core_addr),
    .core_be            (core_be),
    .core_wdata         (core_wdata),
    .core_gnt           (core_gnt),
    .core_rvalid        (core_rvalid),
    .core_rdata         (core_rdata),
    .usb_req            (usb_req),
    .usb_we             (usb_we),
    .usb_addr           (usb_addr),
    .usb_be             (usb_be),
    .usb_wdata          (usb_wdata),
    .usb_gnt            (usb_gnt),
    .usb_rvalid         (usb_rvalid),
    .usb_rdata          (usb_rdata),
    .usb_packet_done    (usb_packet_done),
    .core_packet_handled(core_packet_handled),
    .packet_ready       (packet_ready),
    .packet_overrun     (packet_overrun)
`ifdef USB_ARB_CONFLICT_COUNT_EN
    ,
    .conflict_count     (conflict_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s step %0d: got %h want %h", name, cur_step, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive(input vec_t v);
    {core_req, core_we, usb_req, usb_we} = v.req;
    core_addr  = v.caddr;
    core_be    = v.cbe;
    core_wdata = v.cwd;
    usb_addr   = v.uaddr;
    usb_be     = 4'hF;
    usb_wdata  = v.uwd;
    {usb_packet_done, core_packet_handled} = v.ev;
  endtask

  task automatic idle_inputs();
    {core_req, core_we, usb_req, usb_we} = 4'b0000;
    core_addr = 8'h00; core_be = 4'h0; core_wdata = 32'h0;
    usb_addr = 8'h00; usb_be = 4'h0; usb_wdata = 32'h0;
    usb_packet_done = 1'b0; core_packet_handled = 1'b0;
  endtask

  initial begin
    //            req      caddr  cbe      cwd            uaddr  uwd    ev     eg       ecrd   eurd   est
    vecs[0]  = '{4'b0000, 8'h00, 4'h0,    32'h0,         8'h00, 32'h0, 2'b00, 4'b0000, 32'h0, 32'h0, 2'b00};
    vecs[1]  = '{4'b1100, 8'h10, 4'hF,    VD,            8'h00, 32'h0, 2'b00, 4'b1000, 32'h0, 32'h0, 2'b00};
    vecs[2]  = '{4'b1000, 8'h10, 4'h0,    32'h0,         8'h00, 32'h0, 2'b00, 4'b1000, 32'h0, 32'h0, 2'b00};
    vecs[3]  = '{4'b0000, 8'h00, 4'h0,    32'h0,         8'h00, 32'h0, 2'b00, 4'b0010, VD,    32'h0, 2'b00};
    vecs[4]  = '{4'b1100, 8'h05, 4'hF,    32'h11223344,  8'h00, 32'h0, 2'b00, 4'b1000, VD,    32'h0, 2'b00};
    vecs[5]  = '{4'b1100, 8'h05, 4'b0100, 32'h00AB0000,  8'h00, 32'h0, 2'b00, 4'b1000, VD,    32'h0, 2'b00};
    vecs[6]  = '{4'b0010, 8'h00, 4'h0,    32'h0,         8'h05, 32'h0, 2'b00, 4'b0100, VD,    32'h0, 2'b00};
    vecs[7]  = '{4'b1010, 8'h05, 4'h0,    32'h0,         8'h10, 32'h0, 2'b00, 4'b0101, VD,    VX,    2'b00};
    vecs[8]  = '{4'b1000, 8'h05, 4'h0,    32'h0,         8'h00, 32'h0, 2'b00, 4'b1001, VD,    VD,    2'b00};
    vecs[9]  = '{4'b0000, 8'h00, 4'h0,    32'h0,         8'h00, 32'h0, 2'b00, 4'b0010, VX,    VD,    2'b00};
    vecs[10] = '{4'b1010, 8'h10, 4'h0,    32'h0,         8'h05, 32'h0, 2'b00, 4'b0100, VX,    VD,    2'b00};
    vecs[11] = '{4'b1010, 8'h10, 4'h0,    32'h0,         8'h05, 32'h0, 2'b00, 4'b0101, VX,    VX,    2'b00};
    vecs[12] = '{4'b1010, 8'h10, 4'h0,    32'h0,         8'h05, 32'h0, 2'b00, 4'b0101, VX,    VX,    2'b00};
    vecs[13] = '{4'b1010, 8'h10, 4'h0,    32'h0,         8'h05, 32'h0, 2'b00, 4'b1001, VX,    VX,    2'b00};
    vecs[14] = '{4'b1010, 8'h10, 4'h0,    32'h0,         8'h05, 32'h0, 2'b00, 4'b0110, VD,    VX,    2'b00};
    vecs[15] = '{4'b1010, 8'h10, 4'h0,    32'h0,         8'h05, 32'h0, 2'b00, 4'b0101, VD,    VX,    2'b00};
    vecs[16] = '{4'b1010, 8'h10, 4'h0,    32'h0,         8'h05, 32'h0, 2'b00, 4'b0101, VD,    VX,    2'b00};
    vecs[17] = '{4'b1010, 8'h10, 4'h0,    32'h0,         8'h05, 32'h0, 2'b00, 4'b1001, VD,    VX,    2'b00};
    vecs[18] = '{4'b0000, 8'h00, 4'h0,    32'h0,         8'h00, 32'h0, 2'b00, 4'b0010, VD,    VX,    2'b00};
    vecs[19] = '{4'b0000, 8'h00, 4'h0,    32'h0,         8'h00, 32'h0, 2'b10, 4'b0000, VD,    VX,    2'b00};
    vecs[20] = '{4'b0011, 8'h00, 4'h0,    32'h0,         8'h07, VC,    2'b00, 4'b0000, VD,    VX,    2'b10};
    vecs[21] = '{4'b1111, 8'h08, 4'hF,    VM,            8'h07, VC,    2'b00, 4'b1000, VD,    VX,    2'b10};
    vecs[22] = '{4'b0011, 8'h00, 4'h0,    32'h0,         8'h07, VC,    2'b01, 4'b0000, VD,    VX,    2'b10};
    vecs[23] = '{4'b0011, 8'h00, 4'h0,    32'h0,         8'h07, VC,    2'b00, 4'b0100, VD,    VX,    2'b00};
    vecs[24] = '{4'b1000, 8'h07, 4'h0,    32'h0,         8'h00, 32'h0, 2'b00, 4'b1000, VD,    VX,    2'b00};
    vecs[25] = '{4'b0000, 8'h00, 4'h0,    32'h0,         8'h00, 32'h0, 2'b00, 4'b0010, VC,    VX,    2'b00};
    vecs[26] = '{4'b0000, 8'h00, 4'h0,    32'h0,         8'h00, 32'h0, 2'b10, 4'b0000, VC,    VX,    2'b00};
    vecs[27] = '{4'b0000, 8'h00, 4'h0,    32'h0,         8'h00, 32'h0, 2'b10, 4'b0000, VC,    VX,    2'b10};
    vecs[28] = '{4'b0000, 8'h00, 4'h0,    32'h0,         8'h00, 32'h0, 2'b00, 4'b0000, VC,    VX,    2'b11};
    vecs[29] = '{4'b0010, 8'h00, 4'h0,    32'h0,         8'h08, 32'h0, 2'b00, 4'b0100, VC,    VX,    2'b11};
    vecs[30] = '{4'b0000, 8'h00, 4'h0,    32'h0,         8'h00, 32'h0, 2'b01, 4'b0001, VC,    VM,    2'b11};
    vecs[31] = '{4'b0000, 8'h00, 4'h0,    32'h0,         8'h00, 32'h0, 2'b00, 4'b0000, VC,    VM,    2'b00};
    vecs[32] = '{4'b0000, 8'h00, 4'h0,    32'h0,         8'h00, 32'h0, 2'b10, 4'b0000, VC,    VM,    2'b00};
    vecs[33] = '{4'b0000, 8'h00, 4'h0,    32'h0,         8'h00, 32'h0, 2'b11, 4'b0000, VC,    VM,    2'b10};
    vecs[34] = '{4'b0000, 8'h00, 4'h0,    32'h0,         8'h00, 32'h0, 2'b00, 4'b0000, VC,    VM,    2'b00};
    vecs[35] = '{4'b0000, 8'h00, 4'h0,    32'h0,         8'h00, 32'h0, 2'b01, 4'b0000, VC,    VM,    2'b00};
    vecs[36] = '{4'b0000, 8'h00, 4'h0,    32'h0,         8'h00, 32'h0, 2'b00, 4'b0000, VC,    VM,    2'b00};

    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk48);
    @(negedge clk48);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk48);
      #1;
      cur_step = i;
      drive(vecs[i]);
      @(negedge clk48);
      chk("core_gnt",       32'(core_gnt),       32'(vecs[i].eg[3]));
      chk("usb_gnt",        32'(usb_gnt),        32'(vecs[i].eg[2]));
      chk("core_rvalid",    32'(core_rvalid),    32'(vecs[i].eg[1]));
      chk("usb_rvalid",     32'(usb_rvalid),     32'(vecs[i].eg[0]));
      chk("core_rdata",     core_rdata,          vecs[i].ecrd);
      chk("usb_rdata",      usb_rdata,           vecs[i].eurd);
      chk("packet_ready",   32'(packet_ready),   32'(vecs[i].est[1]));
      chk("packet_overrun", 32'(packet_overrun), 32'(vecs[i].est[0]));
    end
`ifdef USB_ARB_CONFLICT_COUNT_EN
    cur_step = NV;
    chk("conflict_count", 32'(conflict_count), 32'd9);
`endif

    // Reset lands on the cycle after a granted read while a packet is owned by the core.
    cur_step = 100;
    @(posedge clk48); #1;
    idle_inputs();
    usb_packet_done = 1'b1;
    @(posedge clk48); #1;
    idle_inputs();
    core_req = 1'b1; core_addr = 8'h10;
    @(negedge clk48);
    chk("rst_pre_gnt",   32'(core_gnt),     32'd1);
    chk("rst_pre_ready", 32'(packet_ready), 32'd1);
    @(posedge clk48); #1;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    cur_step = 101;
    chk("rst_rvalid",  32'(core_rvalid),    32'd0);
    chk("rst_rdata",   core_rdata,          32'h0);
    chk("rst_ready",   32'(packet_ready),   32'd0);
    chk("rst_overrun", 32'(packet_overrun), 32'd0);
`ifdef USB_ARB_CONFLICT_COUNT_EN
    chk("rst_conflict", 32'(conflict_count), 32'd0);
`endif
    @(negedge clk48);
    chk("rst_hold_rvalid", 32'(core_rvalid), 32'd0);
    rst_n = 1'b1;

    // RAM contents survive reset.
    cur_step = 102;
    @(posedge clk48); #1;
    core_req = 1'b1; core_addr = 8'h10;
    @(negedge clk48);
    chk("post_rst_gnt", 32'(core_gnt), 32'd1);
    @(posedge clk48); #1;
    idle_inputs();
    @(negedge clk48);
    chk("post_rst_rvalid", 32'(core_rvalid),  32'd1);
    chk("post_rst_rdata",  core_rdata,        VD);
    chk("post_rst_ready",  32'(packet_ready), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
